// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive word assembler.
// Contents:
//   spi_rx_state_t  - FSM state encoding (IDLE, SHIFT)
//   BITS_PER_BYTE   - serial bits per byte
//   WORD_BYTES_MIN  - smallest supported word, in bytes
//   WORD_BYTES_MAX  - largest supported word, in bytes
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_rx_state_t;

  localparam int BITS_PER_BYTE  = 8;
  localparam int WORD_BYTES_MIN = 2;
  localparam int WORD_BYTES_MAX = 8;

endpackage

// File: rtl/spi_rx_assembler_if.sv
// Bundle of serial-side, handshake and status signals for spi_rx_assembler.
// Parameter: WORD_BYTES - bytes per assembled word.
// Signals:
//   cs_n, sample_en, mosi - synchronised frame select, bit strobe, serial bit
//   rx_ready, ovf_clr     - downstream accept, overflow clear
//   rx_word, rx_valid     - assembled word and its valid flag
//   overflow, frame_err   - sticky drop flag, one-cycle short-frame pulse
//   busy, bit_idx, byte_idx - FSM in SHIFT, current bit/byte position
// Modports: master drives the serial side and handshake; slave is the assembler.
interface spi_rx_assembler_if
  import spi_pkg::*;
#(
  parameter int WORD_BYTES = 4
);

  localparam int WORD_W     = BITS_PER_BYTE * WORD_BYTES;
  localparam int BYTE_IDX_W = $clog2(WORD_BYTES);

  logic                  cs_n;
  logic                  sample_en;
  logic                  mosi;
  logic                  rx_ready;
  logic                  ovf_clr;
  logic [WORD_W-1:0]     rx_word;
  logic                  rx_valid;
  logic                  overflow;
  logic                  frame_err;
  logic                  busy;
  logic [2:0]            bit_idx;
  logic [BYTE_IDX_W-1:0] byte_idx;

  modport master (
    output cs_n, sample_en, mosi, rx_ready, ovf_clr,
    input  rx_word, rx_valid, overflow, frame_err, busy, bit_idx, byte_idx
  );

  modport slave (
    input  cs_n, sample_en, mosi, rx_ready, ovf_clr,
    output rx_word, rx_valid, overflow, frame_err, busy, bit_idx, byte_idx
  );

endinterface

// File: rtl/spi_rx_pos_counter.sv
// Bit/byte position counter for the SPI receive assembler.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr        - synchronous clear of both positions
//   en         - advance by one bit
//   bit_idx    - bit position within the current byte
//   byte_idx   - byte position within the current word
//   word_wrap  - combinational: this enabled bit completes the word
module spi_rx_pos_counter
  import spi_pkg::*;
#(
  parameter  int WORD_BYTES = 4,
  localparam int BYTE_IDX_W = $clog2(WORD_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [2:0]            bit_idx,
  output logic [BYTE_IDX_W-1:0] byte_idx,
  output logic                  word_wrap
);

  localparam logic [2:0]            LAST_BIT  = 3'(BITS_PER_BYTE - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(WORD_BYTES - 1);

  assign word_wrap = en && (bit_idx == LAST_BIT) && (byte_idx == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bit_idx  <= '0;
      byte_idx <= '0;
    end else if (en) begin
      if (bit_idx == LAST_BIT) begin
        bit_idx  <= '0;
        // Explicit wrap: WORD_BYTES need not be a power of two.
        byte_idx <= (byte_idx == LAST_BYTE) ? '0 : byte_idx + 1'b1;
      end else begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_rx_assembler.sv
// SPI receive word assembler: collects serial bits strobed by sample_en while
// cs_n is low into WORD_BYTES-byte words (byte 0 in the top byte) and hands
// each completed word to a valid/ready consumer through a one-word buffer.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - spi_rx_assembler_if.slave (serial inputs, handshake, status)
// Build option: define SPI_RX_LSB_FIRST_EN to receive each byte LSB-first;
// by default each byte arrives MSB-first.
module spi_rx_assembler
  import spi_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input logic                clk,
  input logic                rst,
  spi_rx_assembler_if.slave  bus
);

  localparam int WORD_W     = BITS_PER_BYTE * WORD_BYTES;
  localparam int IDX_W      = $clog2(WORD_W);
  localparam int BYTE_IDX_W = $clog2(WORD_BYTES);

  spi_rx_state_t         state_q, state_d;
  logic                  capture;
  logic                  word_done;
  logic                  busy_c;
  logic                  ferr_set;
  logic [2:0]            bit_idx;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic [WORD_W-1:0]     partial_q;
  logic [WORD_W-1:0]     assembled;
  logic [WORD_W-1:0]     rx_word_q;
  logic                  rx_valid_q;
  logic                  overflow_q;
  logic                  frame_err_q;

  // A strobe counts whenever cs_n is low, including the IDLE->SHIFT cycle.
  assign capture = bus.sample_en && !bus.cs_n;

  spi_rx_pos_counter #(
    .WORD_BYTES (WORD_BYTES)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.cs_n),
    .en        (capture),
    .bit_idx   (bit_idx),
    .byte_idx  (byte_idx),
    .word_wrap (word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.cs_n) state_d = SHIFT;
      SHIFT:   if (bus.cs_n)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_c   = (state_q == SHIFT);
    ferr_set = busy_c && bus.cs_n && ((bit_idx != 3'd0) || (byte_idx != '0));
  end

  // Target bit of the incoming sample: byte 0 occupies the top byte.
`ifdef SPI_RX_LSB_FIRST_EN
  assign wr_idx = IDX_W'((WORD_BYTES - 1 - int'(byte_idx)) * BITS_PER_BYTE
                         + int'(bit_idx));
`else
  assign wr_idx = IDX_W'((WORD_BYTES - 1 - int'(byte_idx)) * BITS_PER_BYTE
                         + (BITS_PER_BYTE - 1 - int'(bit_idx)));
`endif

  // Word including the bit being captured this cycle, so a completed word can
  // be buffered in the same edge as its final sample.
  always_comb begin
    assembled         = partial_q;
    assembled[wr_idx] = bus.mosi;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.cs_n)     partial_q <= '0;
    else if (word_done)      partial_q <= '0;
    else if (capture)        partial_q <= assembled;
  end

  // One-word output buffer; a completed word is accepted when the buffer is
  // empty or being drained in the same cycle, otherwise it is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_word_q   <= '0;
      rx_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (word_done && (!rx_valid_q || bus.rx_ready)) begin
        rx_word_q  <= assembled;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      if (word_done && rx_valid_q && !bus.rx_ready) overflow_q <= 1'b1;
      else if (bus.ovf_clr)                         overflow_q <= 1'b0;

      frame_err_q <= ferr_set;
    end
  end

  assign bus.rx_word   = rx_word_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_c;
  assign bus.bit_idx   = bit_idx;
  assign bus.byte_idx  = byte_idx;

endmodule

// File: tb/tb_spi_rx_assembler.sv
// Directed self-checking bench for spi_rx_assembler (WORD_BYTES=4).
// Serial bit order follows SPI_RX_LSB_FIRST_EN so the same vectors apply to
// both builds.
module tb_spi_rx_assembler;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   ferr_cnt = 0;
  int   f0;

  always #5 clk = ~clk;

  spi_rx_assembler_if #(.WORD_BYTES(4)) bus ();

  spi_rx_assembler #(.WORD_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(negedge clk) if (bus.frame_err === 1'b1) ferr_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Serial bit number i (0 = first on the wire) of word w.
  function automatic logic wire_bit(input logic [31:0] w, input int i);
    int b;
    int k;
    b = i / 8;
    k = i % 8;
`ifdef SPI_RX_LSB_FIRST_EN
    return w[24 - 8*b + k];
`else
    return w[31 - 8*b - k];
`endif
  endfunction

  task automatic send_bits(input logic [31:0] w, input int from, input int upto, input int gap);
    for (int i = from; i <= upto; i++) begin
      bus.sample_en = 1'b1;
      bus.mosi      = wire_bit(w, i);
      tick();
      bus.sample_en = 1'b0;
      if (i < upto) repeat (gap) tick();
    end
    bus.sample_en = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.cs_n      = 1'b0;
    bus.sample_en = 1'b1;
    bus.mosi      = 1'b1;
    bus.rx_ready  = 1'b0;
    bus.ovf_clr   = 1'b0;
    repeat (3) tick();
    chk("rst_valid",   64'(bus.rx_valid),  64'd0);
    chk("rst_word",    64'(bus.rx_word),   64'd0);
    chk("rst_ovf",     64'(bus.overflow),  64'd0);
    chk("rst_ferr",    64'(bus.frame_err), 64'd0);
    chk("rst_busy",    64'(bus.busy),      64'd0);
    chk("rst_bit",     64'(bus.bit_idx),   64'd0);
    chk("rst_byte",    64'(bus.byte_idx),  64'd0);
    rst           = 1'b0;
    bus.cs_n      = 1'b1;
    bus.sample_en = 1'b0;
    tick();

    // Strobes while deselected are ignored.
    send_bits(32'hFFFF_FFFF, 0, 4, 0);
    chk("idle_ignore_bit", 64'(bus.bit_idx), 64'd0);
    chk("idle_busy",       64'(bus.busy),    64'd0);

    // Single word, consumer ready, with idle gaps between strobes.
    bus.rx_ready = 1'b1;
    bus.cs_n     = 1'b0;
    send_bits(32'hA5C3_0F96, 0, 30, 1);
    chk("t1_busy",      64'(bus.busy),     64'd1);
    chk("t1_pre_valid", 64'(bus.rx_valid), 64'd0);
    send_bits(32'hA5C3_0F96, 31, 31, 0);
    chk("t1_valid",     64'(bus.rx_valid), 64'd1);
    chk("t1_word",      64'(bus.rx_word),  64'hA5C3_0F96);
    tick();
    chk("t1_consumed",  64'(bus.rx_valid), 64'd0);
    bus.cs_n = 1'b1;
    tick();
    chk("t1_no_ferr",   64'(bus.frame_err), 64'd0);
    chk("t1_idle",      64'(bus.busy),      64'd0);
    chk("t1_ferr_cnt",  64'(ferr_cnt),      64'd0);

    // Back-to-back words, consumer stalled: second word dropped.
    bus.rx_ready = 1'b0;
    bus.cs_n     = 1'b0;
    send_bits(32'h1122_3344, 0, 31, 0);
    chk("t2_valid1",  64'(bus.rx_valid), 64'd1);
    chk("t2_word1",   64'(bus.rx_word),  64'h1122_3344);
    chk("t2_ovf0",    64'(bus.overflow), 64'd0);
    send_bits(32'h5566_7788, 0, 31, 0);
    chk("t2_held",    64'(bus.rx_word),  64'h1122_3344);
    chk("t2_valid2",  64'(bus.rx_valid), 64'd1);
    chk("t2_ovf1",    64'(bus.overflow), 64'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr", 64'(bus.overflow), 64'd0);
    // Clear held across another dropped completion: the set wins.
    bus.ovf_clr = 1'b1;
    send_bits(32'h0BAD_CAFE, 0, 31, 0);
    bus.ovf_clr = 1'b0;
    chk("t2_set_wins", 64'(bus.overflow), 64'd1);
    chk("t2_held2",    64'(bus.rx_word),  64'h1122_3344);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr2", 64'(bus.overflow), 64'd0);
    bus.cs_n = 1'b1;
    tick();
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    chk("t2_drained", 64'(bus.rx_valid), 64'd0);

    // Frame ends after 13 bits while a word is buffered.
    bus.cs_n = 1'b0;
    send_bits(32'hCAFE_F00D, 0, 31, 0);
    f0 = ferr_cnt;
    send_bits(32'h9696_9696, 0, 12, 0);
    chk("t3_bit_mid",  64'(bus.bit_idx),  64'd5);
    chk("t3_byte_mid", 64'(bus.byte_idx), 64'd1);
    bus.cs_n = 1'b1;
    tick();
    chk("t3_ferr",     64'(bus.frame_err), 64'd1);
    chk("t3_bit_clr",  64'(bus.bit_idx),   64'd0);
    chk("t3_byte_clr", 64'(bus.byte_idx),  64'd0);
    chk("t3_valid",    64'(bus.rx_valid),  64'd1);
    chk("t3_word",     64'(bus.rx_word),   64'hCAFE_F00D);
    tick();
    chk("t3_ferr_off", 64'(bus.frame_err), 64'd0);
    chk("t3_ferr_len", 64'(ferr_cnt - f0), 64'd1);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;

    // Completion in the same cycle the buffered word is consumed.
    bus.cs_n = 1'b0;
    send_bits(32'h1234_5678, 0, 31, 0);
    chk("t4_valid1", 64'(bus.rx_valid), 64'd1);
    send_bits(32'h9ABC_DEF0, 0, 30, 0);
    bus.rx_ready = 1'b1;
    send_bits(32'h9ABC_DEF0, 31, 31, 0);
    chk("t4_valid",  64'(bus.rx_valid), 64'd1);
    chk("t4_word",   64'(bus.rx_word),  64'h9ABC_DEF0);
    chk("t4_ovf",    64'(bus.overflow), 64'd0);
    tick();
    chk("t4_drain",  64'(bus.rx_valid), 64'd0);
    bus.rx_ready = 1'b0;
    bus.cs_n     = 1'b1;
    tick();

    // Reset mid-frame, then a fresh word with cs_n still low.
    bus.cs_n = 1'b0;
    f0 = ferr_cnt;
    send_bits(32'hFFFF_FFFF, 0, 19, 0);
    chk("t5_bit_pre", 64'(bus.bit_idx), 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_bit_rst",  64'(bus.bit_idx),  64'd0);
    chk("t5_byte_rst", 64'(bus.byte_idx), 64'd0);
    chk("t5_busy_rst", 64'(bus.busy),     64'd0);
    send_bits(32'hDEAD_BEEF, 0, 31, 0);
    chk("t5_valid", 64'(bus.rx_valid), 64'd1);
    chk("t5_word",  64'(bus.rx_word),  64'hDEAD_BEEF);
    bus.cs_n = 1'b1;
    tick();
    chk("t5_no_ferr", 64'(ferr_cnt - f0), 64'd0);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;

    // Per-byte bit order (follows the build option).
    bus.cs_n = 1'b0;
    send_bits(32'h0102_0304, 0, 31, 2);
    chk("t6_valid", 64'(bus.rx_valid), 64'd1);
    chk("t6_word",  64'(bus.rx_word),  64'h0102_0304);
    bus.cs_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx_assembler.md
SPI_RX_ASSEMBLER -- requirements
Module: spi_rx_assembler

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4, giving the bytes per assembled word (legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cs_n, input, 1 bit: frame select, active low, already synchronised to clk.
REQ-005 SHALL have port sample_en, input, 1 bit: one-cycle strobe, with mosi valid when it is high.
REQ-006 SHALL have port mosi, input, 1 bit: serial data bit.
REQ-007 SHALL have port rx_ready, input, 1 bit: downstream accepts rx_word.
REQ-008 SHALL have port ovf_clr, input, 1 bit: clears overflow.
REQ-009 SHALL have port rx_word, output, 8*WORD_BYTES bits: assembled word.
REQ-010 SHALL have port rx_valid, output, 1 bit: rx_word holds an unconsumed word.
REQ-011 SHALL have port overflow, output, 1 bit: sticky, set when a completed word was dropped.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame ends mid-word.
REQ-013 SHALL have port busy, output, 1 bit: high in SHIFT state.
REQ-014 SHALL have port bit_idx, output, 3 bits: current bit position.
REQ-015 SHALL have port byte_idx, output, $clog2(WORD_BYTES) bits: current byte position.

Function
REQ-016 SHALL implement FSM states IDLE and SHIFT.
REQ-017 SHALL move IDLE->SHIFT in the cycle cs_n is sampled low; a sample_en in that same cycle SHALL be captured as bit 0.
REQ-018 SHALL move SHIFT->IDLE in the cycle cs_n is sampled high, clearing bit_idx, byte_idx and the partial word; a sample_en in that same cycle SHALL be ignored.
REQ-019 SHALL ignore sample_en while cs_n is high.
REQ-020 SHALL, on each captured bit, shift mosi into the current byte MSB-first and increment bit_idx; when bit_idx is 7 it SHALL wrap to 0 and increment byte_idx.
REQ-021 SHALL place byte 0 in rx_word[8*WORD_BYTES-1 -: 8], with later bytes following toward the LSB.
REQ-022 SHALL, when the last bit of byte WORD_BYTES-1 is captured, complete the word, wrap byte_idx to 0, and stay in SHIFT; back-to-back words within one frame SHALL be supported with no lost bits.
REQ-023 SHALL, on word completion, load rx_word and assert rx_valid at the next clk edge (latency 1 cycle from the final sample_en).
REQ-024 SHALL hold rx_valid and rx_word stable until a cycle with rx_valid && rx_ready, then deassert rx_valid at the next edge.
REQ-025 SHALL, when completion coincides with rx_valid && rx_ready, load the new word and keep rx_valid at 1.
REQ-026 SHALL, when completion occurs with rx_valid=1 and rx_ready=0, drop the new word, keep the old word, and set overflow.
REQ-027 SHALL clear overflow on ovf_clr; if ovf_clr coincides with a new overflow event, the set SHALL win.
REQ-028 SHALL pulse frame_err for exactly one cycle when cs_n rises in SHIFT with bit_idx!=0 or byte_idx!=0; a frame ending on a word boundary SHALL give no error.
REQ-029 SHALL leave rx_valid and the buffered word unaffected by cs_n edges.

Reset
REQ-030 SHALL, while rst=1 at a clk edge, set state IDLE, bit_idx=0, byte_idx=0, rx_word=0, rx_valid=0, overflow=0, frame_err=0 and busy=0, overriding all other inputs.
REQ-031 SHALL, on reset asserted mid-frame, discard the partial word without a frame_err pulse; after reset release with cs_n still low, the block SHALL enter SHIFT and start a fresh word.

Configuration
REQ-032 SHALL, with macro SPI_RX_LSB_FIRST_EN defined, shift each byte LSB-first, so the first captured bit lands in bit 0 of the byte.
REQ-033 SHALL, without SPI_RX_LSB_FIRST_EN, shift MSB-first as in REQ-020; byte order, handshake and timing SHALL be identical in both builds.

Structure
REQ-034 SHALL take state enum type spi_rx_state_t, BITS_PER_BYTE=8 and the WORD_BYTES legal-range constants from shared package spi_pkg.
REQ-035 SHALL place the bit/byte position counters (sync clear, enable, wrap flag) in sub-module spi_rx_pos_counter; the FSM, shifter and output buffer SHALL remain in spi_rx_assembler.

Verification
REQ-036 SHALL cover: cs_n low, 32 strobes carrying 0xA5C3_0F96 MSB-first, rx_ready=1 -> rx_word=0xA5C30F96, rx_valid for 1 cycle, 1 cycle after the last strobe.
REQ-037 SHALL cover: two back-to-back words 0x11223344 and 0x55667788 in one frame, rx_ready=0 -> first word held, overflow=1, ovf_clr -> overflow=0.
REQ-038 SHALL cover: cs_n high after 13 bits -> frame_err pulse of 1 cycle, bit_idx=0, byte_idx=0, rx_valid unchanged.
REQ-039 SHALL cover: completion in the same cycle as rx_valid && rx_ready -> new word loaded, rx_valid stays 1, overflow=0.
REQ-040 SHALL cover: rst=1 after 20 bits, then 32 bits of 0xDEADBEEF -> rx_word=0xDEADBEEF, no frame_err.
REQ-041 SHALL cover: LSB_FIRST build, serial bytes sent LSB-first for 0x01020304 -> rx_word=0x01020304.
